// File: rtl/mem_wb_stage.sv
// mem_wb_stage: data-memory access plus MEM/WB buffer and write-back mux C.
// Ports: clock/reset, hold, mem_* EX/MEM inputs, wb_* outputs; ALIGN_CHECK_EN.
module mem_wb_stage #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256,
  parameter int REG_W  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              hold,
  input  logic              mem_reg_wrt_ctrl,
  input  logic              mem_data_mem_wrt_ctrl,
  input  logic              mem_data_mem_byte_ctrl,
  input  logic              mem_muxc,
  input  logic              mem_halt,
  input  logic [DATA_W-1:0] mem_alu_output,
  input  logic [DATA_W-1:0] mem_alu_r0_result,
  input  logic [DATA_W-1:0] mem_store_data,
  input  logic [REG_W-1:0]  mem_op1,
  output logic [DATA_W-1:0] mem_ex_forwarded_alu_output,
  output logic              wb_reg_wrt_ctrl,
  output logic [REG_W-1:0]  wb_op1,
  output logic [DATA_W-1:0] wb_data_line,
  output logic [DATA_W-1:0] wb_alu_output,
  output logic [DATA_W-1:0] wb_alu_r0_result,
  output logic              mux_c_wb_data_ctrl,
  output logic [DATA_W-1:0] wb_id_write_data,
  output logic              wb_halt,
  output logic              wb_misalign
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic              rw;
    logic [REG_W-1:0]  op1;
    logic [DATA_W-1:0] dl;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] r0;
    logic              mc;
    logic              mis;
  } mem_wb_t;

  typedef enum logic {RUN, HALTED} halt_e;

  halt_e          state;
  mem_wb_t        wb;
  mem_wb_t        nxt;
  logic [7:0]     mem [DEPTH];
  logic [AW-1:0]  a0;
  logic [AW-1:0]  a1;
  logic [DATA_W-1:0] ld;
  logic           mis;
  logic           we;
  logic           unused_hi;

  assign a0 = mem_alu_output[AW-1:0];
  assign a1 = a0 + 1'b1;
  assign unused_hi = ^mem_alu_output[DATA_W-1:AW];

`ifdef ALIGN_CHECK_EN
  // only real memory accesses (load via mux C, or store) can fault
  assign mis = ~mem_data_mem_byte_ctrl & a0[0]
             & (mem_muxc | mem_data_mem_wrt_ctrl);
`else
  assign mis = 1'b0;
`endif

  always_comb begin
    ld = {mem[a0], mem[a1]};
    if (mem_data_mem_byte_ctrl)
      ld = {{(DATA_W-8){mem[a0][7]}}, mem[a0]};
  end

  assign we = mem_data_mem_wrt_ctrl & ~hold
            & (state == RUN) & ~mis;

  always_comb begin
    nxt     = '0;
    nxt.rw  = mem_reg_wrt_ctrl & ~mis;
    nxt.op1 = mem_op1;
    nxt.dl  = mis ? '0 : ld;
    nxt.alu = mem_alu_output;
    nxt.r0  = mem_alu_r0_result;
    nxt.mc  = mem_muxc;
    nxt.mis = mis;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= RUN;
      wb    <= '0;
    end else if (!hold) begin
      wb <= nxt;
      if (mem_halt)
        state <= HALTED;
    end
  end

  // contents are not reset; a low reset at the edge blocks the write
  always_ff @(posedge clock or negedge reset) begin
    if (reset && we) begin
      if (mem_data_mem_byte_ctrl) begin
        mem[a0] <= mem_store_data[7:0];
      end else begin
        mem[a0] <= mem_store_data[15:8];
        mem[a1] <= mem_store_data[7:0];
      end
    end
  end

  assign mem_ex_forwarded_alu_output = mem_alu_output;
  assign wb_reg_wrt_ctrl    = wb.rw & (state == RUN);
  assign wb_op1             = wb.op1;
  assign wb_data_line       = wb.dl;
  assign wb_alu_output      = wb.alu;
  assign wb_alu_r0_result   = wb.r0;
  assign mux_c_wb_data_ctrl = wb.mc;
  assign wb_id_write_data   = wb.mc ? wb.dl : wb.alu;
  assign wb_halt            = (state == HALTED);
  assign wb_misalign        = wb.mis;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: random + directed bench for mem_wb_stage
// against a byte-array reference model of memory, halt and MEM/WB fields.
module tb_mem_wb_stage;

  logic        clock;
  logic        reset;
  logic        hold;
  logic        rw, st, bt, mc, hl;
  logic [15:0] alu, r0, sd;
  logic [3:0]  op;
  logic [15:0] fwd;
  logic        o_rw;
  logic [3:0]  o_op;
  logic [15:0] o_dl, o_alu, o_r0, o_wd;
  logic        o_mc, o_halt, o_mis;

  mem_wb_stage dut (
    .clock                       (clock),
    .reset                       (reset),
    .hold                        (hold),
    .mem_reg_wrt_ctrl            (rw),
    .mem_data_mem_wrt_ctrl       (st),
    .mem_data_mem_byte_ctrl      (bt),
    .mem_muxc                    (mc),
    .mem_halt                    (hl),
    .mem_alu_output              (alu),
    .mem_alu_r0_result           (r0),
    .mem_store_data              (sd),
    .mem_op1                     (op),
    .mem_ex_forwarded_alu_output (fwd),
    .wb_reg_wrt_ctrl             (o_rw),
    .wb_op1                      (o_op),
    .wb_data_line                (o_dl),
    .wb_alu_output               (o_alu),
    .wb_alu_r0_result            (o_r0),
    .mux_c_wb_data_ctrl          (o_mc),
    .wb_id_write_data            (o_wd),
    .wb_halt                     (o_halt),
    .wb_misalign                 (o_mis)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

`ifdef ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  byte unsigned mm [256];
  bit          halted;
  bit          e_rw, e_mc, e_mis;
  logic [3:0]  e_op;
  logic [15:0] e_dl, e_alu, e_r0;

  task automatic check(input string tag,
                       input logic [15:0] got,
                       input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    check("wb_rw", 16'(o_rw), 16'(e_rw && !halted));
    check("wb_op1", 16'(o_op), 16'(e_op));
    check("wb_dl", o_dl, e_dl);
    check("wb_alu", o_alu, e_alu);
    check("wb_r0", o_r0, e_r0);
    check("muxc", 16'(o_mc), 16'(e_mc));
    check("wdata", o_wd, e_mc ? e_dl : e_alu);
    check("halt", 16'(o_halt), 16'(halted));
    check("misal", 16'(o_mis), 16'(e_mis));
  endtask

  // reference: one instruction's effect at the clock edge
  task automatic model_edge();
    int a;
    int b;
    bit f;
    logic [15:0] ld;
    if (hold) return;
    a  = int'(alu) % 256;
    b  = (a + 1) % 256;
    f  = ALIGN && !bt && (a % 2 == 1) && (mc || st);
    if (bt) ld = {{8{mm[a][7]}}, mm[a]};
    else    ld = {mm[a], mm[b]};
    if (st && !halted && !f) begin
      if (bt) mm[a] = sd[7:0];
      else begin
        mm[a] = sd[15:8];
        mm[b] = sd[7:0];
      end
    end
    e_rw  = rw && !f;
    e_op  = op;
    e_dl  = f ? 16'h0 : ld;
    e_alu = alu;
    e_r0  = r0;
    e_mc  = mc;
    e_mis = f;
    if (hl) halted = 1'b1;
  endtask

  task automatic cyc(input bit h, input bit irw,
                     input bit ist, input bit ibt,
                     input bit imc, input bit ihl,
                     input logic [15:0] ialu,
                     input logic [15:0] ir0,
                     input logic [15:0] isd,
                     input logic [3:0] iop);
    hold = h; rw = irw; st = ist; bt = ibt;
    mc = imc; hl = ihl; alu = ialu; r0 = ir0;
    sd = isd; op = iop;
    #1;
    check("fwd", fwd, ialu);
    @(posedge clock);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    halted = 1'b0;
    e_rw = 0; e_mc = 0; e_mis = 0;
    e_op = '0; e_dl = '0; e_alu = '0; e_r0 = '0;
    check_all();
    // store while in reset must be dropped
    hold = 0; st = 1; bt = 0; rw = 1; mc = 0; hl = 0;
    alu = 16'h0010; sd = 16'hDEAD;
    repeat (2) @(posedge clock);
    #1;
    check_all();
    @(negedge clock);
    reset = 1'b1;
    st = 0;
  endtask

  task automatic st_w(input logic [15:0] a, input logic [15:0] d);
    cyc(0, 0, 1, 0, 0, 0, a, 16'h0, d, 4'h0);
  endtask
  task automatic st_b(input logic [15:0] a, input logic [15:0] d);
    cyc(0, 0, 1, 1, 0, 0, a, 16'h0, d, 4'h0);
  endtask
  task automatic ld_w(input logic [15:0] a, input logic [3:0] r);
    cyc(0, 1, 0, 0, 1, 0, a, 16'h0, 16'h0, r);
  endtask
  task automatic ld_b(input logic [15:0] a, input logic [3:0] r);
    cyc(0, 1, 0, 1, 1, 0, a, 16'h0, 16'h0, r);
  endtask

  initial begin
    reset = 1; hold = 0; rw = 0; st = 0; bt = 0; mc = 0; hl = 0;
    alu = '0; r0 = '0; sd = '0; op = '0;
    halted = 0;
    @(negedge clock);
    do_reset();
    for (int i = 0; i < 256; i++)
      st_b(16'(i), 16'(i ^ 8'h5A));

    st_w(16'h0010, 16'hBEEF);
    ld_w(16'h0010, 4'd3);
    check("beef", o_wd, 16'hBEEF);
    check("beef_op", 16'(o_op), 16'd3);

    st_b(16'h0021, 16'h1280);
    ld_b(16'h0021, 4'd4);
    check("sext", o_dl, 16'hFF80);
    ld_w(16'h0020, 4'd5);
    check("lowb", 16'(o_dl[7:0]), 16'h0080);

    cyc(1, 1, 1, 0, 0, 0, 16'h0030, 16'h0, 16'h1234, 4'd9);
    cyc(1, 1, 1, 0, 0, 1, 16'h0030, 16'h0, 16'h1234, 4'd9);
    check("hold_op", 16'(o_op), 16'd5);
    check("hold_h", 16'(o_halt), 16'd0);
    ld_w(16'h0030, 4'd6);
    check("hold_mem", o_dl, {8'h30 ^ 8'h5A, 8'h31 ^ 8'h5A});
    st_w(16'h0030, 16'h1234);
    ld_w(16'h0030, 4'd6);
    check("hold_st", o_dl, 16'h1234);

    cyc(0, 0, 0, 0, 0, 1, 16'h0, 16'h0, 16'h0, 4'd0);
    check("halted", 16'(o_halt), 16'd1);
    st_w(16'h0010, 16'h5555);
    ld_w(16'h0010, 4'd7);
    check("h_rw", 16'(o_rw), 16'd0);
    check("h_mem", o_dl, 16'hBEEF);
    @(negedge clock);
    do_reset();
    ld_w(16'h0010, 4'd3);
    check("rst_mem", o_wd, 16'hBEEF);

    cyc(0, 1, 0, 0, 0, 0, 16'h0042, 16'h0007, 16'h0, 4'd2);
    check("alu_wd", o_wd, 16'h0042);
    check("alu_r0", o_r0, 16'h0007);

    st_w(16'h0011, 16'hAAAA);
    check("misal_st", 16'(o_mis), 16'(ALIGN));
    ld_b(16'h0011, 4'd1);
    check("al_11", 16'(o_dl[7:0]), ALIGN ? 16'h00EF : 16'h00AA);
    ld_b(16'h0012, 4'd1);
    check("al_12", 16'(o_dl[7:0]),
          ALIGN ? 16'(8'h12 ^ 8'h5A) : 16'h00AA);
    st_w(16'h00FF, 16'h1357);
    ld_b(16'h00FF, 4'd1);
    check("wrapff", 16'(o_dl[7:0]),
          ALIGN ? 16'(8'hFF ^ 8'h5A) : 16'h0013);
    ld_b(16'h0100, 4'd1);
    check("wrap00", 16'(o_dl[7:0]),
          ALIGN ? 16'(8'h00 ^ 8'h5A) : 16'h0057);

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(299) == 0) begin
        @(negedge clock);
        do_reset();
      end
      cyc($urandom_range(4) == 0, 1'($urandom),
          $urandom_range(2) == 0, 1'($urandom),
          1'($urandom), $urandom_range(199) == 0,
          16'($urandom), 16'($urandom),
          16'($urandom), 4'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory-access stage plus MEM/WB pipeline buffer of the 16-bit pipelined CPU. It consumes the EX/MEM buffer outputs: ALU result or address, R0 result, store data, destination register and control bits. It performs byte- or word-wide data-memory loads and stores, then registers everything the write-back stage and the forwarding unit need. It also produces the final register-file write data through the write-back selector (mux C).

## Interface
- DATA_W, 16, datapath width; must be 16
- DEPTH, 256, data memory size in bytes; power of two
- REG_W, 4, register-index width
- clock  in  1  system clock, rising-edge
- reset  in  1  asynchronous, active-low
- hold  in  1  stall: MEM/WB register keeps its value, memory write suppressed
- mem_reg_wrt_ctrl  in  1  instruction writes the register file
- mem_data_mem_wrt_ctrl  in  1  store enable
- mem_data_mem_byte_ctrl  in  1  1 = byte access, 0 = word access
- mem_muxc  in  1  write-back source: 1 = memory data, 0 = ALU output
- mem_halt  in  1  HALT instruction in MEM
- mem_alu_output  in  DATA_W  ALU result / effective byte address
- mem_alu_r0_result  in  DATA_W  secondary (R0) result of multiply/divide
- mem_store_data  in  DATA_W  store data
- mem_op1  in  REG_W  destination register
- mem_ex_forwarded_alu_output  out  DATA_W  combinational copy of mem_alu_output, for forwarding
- wb_reg_wrt_ctrl  out  1  registered write enable
- wb_op1  out  REG_W  registered destination
- wb_data_line  out  DATA_W  registered load data
- wb_alu_output  out  DATA_W  registered ALU result
- wb_alu_r0_result  out  DATA_W  registered R0 result
- mux_c_wb_data_ctrl  out  1  registered mem_muxc
- wb_id_write_data  out  DATA_W  combinational: mux_c_wb_data_ctrl ? wb_data_line : wb_alu_output
- wb_halt  out  1  sticky halt indication
- wb_misalign  out  1  registered misaligned-word flag (only with ALIGN_CHECK_EN)

## Operation
- Byte addresses are taken modulo DEPTH: only the low log2(DEPTH) bits of mem_alu_output are used.
- Memory is byte-wide and big-endian.
  - Word at address a: high byte at mem[a], low byte at mem[(a+1) mod DEPTH].
  - Wrap-around at DEPTH-1 is legal when alignment checking is compiled out.
- Loads are combinational reads into the MEM/WB register.
  - Byte load: sign-extended to 16 bits.
  - Word load: {mem[a], mem[a+1]}.
- Stores are synchronous, on the rising edge.
  - A store occurs only if mem_data_mem_wrt_ctrl=1, hold=0, the halt state is not set, and no misalign fault is active.
  - Byte store writes mem_store_data[7:0] to mem[a].
  - Word store writes [15:8] to mem[a] and [7:0] to mem[a+1].
- A load in the cycle after a store to the same address returns the new data. The write has already occurred on that edge.
- Memory contents are not reset.
- Halt state machine has two states, RUN and HALTED.
  - RUN -> HALTED on a rising edge with mem_halt=1 and hold=0.
  - HALTED persists until reset. wb_halt=1 in HALTED.
  - In HALTED, all stores are blocked and wb_reg_wrt_ctrl is forced to 0. Other MEM/WB fields still update.
- Simultaneous hold=1 and mem_halt=1: the halt is not taken until hold deasserts.

## Timing
- MEM/WB register latency is 1 cycle: inputs sampled at edge N appear on the wb_* outputs after edge N.
- The store takes effect at the same edge that captures the instruction into MEM/WB.
- Outputs while reset=0, asserted asynchronously:
  - wb_reg_wrt_ctrl=0, wb_op1=0, wb_data_line=0, wb_alu_output=0, wb_alu_r0_result=0, mux_c_wb_data_ctrl=0, wb_halt=0, wb_misalign=0.
  - Halt state returns to RUN.
- Reset asserted mid-store: that store is not performed.
- hold=1: every MEM/WB field is unchanged and no store occurs. The combinational outputs follow the held register values.

## Configuration
- ALIGN_CHECK_EN defined:
  - A word access (byte_ctrl=0, load or store) with an odd address is a misalign fault.
  - On a fault the store is suppressed, wb_data_line is captured as 0, wb_reg_wrt_ctrl is captured as 0, and wb_misalign=1 for that instruction's MEM/WB cycle.
- ALIGN_CHECK_EN undefined:
  - Odd word addresses are legal, with wrap at DEPTH-1.
  - The wb_misalign port exists but is tied to 0.

## Test plan
- Reset then word store: reset=0 for 2 cycles, then word store 0xBEEF at address 0x0010, then word load from 0x0010 with muxc=1, op1=3. Required: wb_id_write_data=0xBEEF, wb_op1=3, wb_reg_wrt_ctrl=1. All wb_* outputs are 0 during reset.
- Byte store and sign extension: byte store 0x1280 at 0x0021, then byte load 0x0021 -> wb_data_line=0xFF80. Word load 0x0020 -> low byte 0x80.
- Hold: hold=1 with a word store 0x1234 at 0x0030. Required: memory unchanged and wb_* outputs frozen. Deassert hold -> store lands; a subsequent load returns 0x1234.
- Halt: mem_halt=1 captured. Required: wb_halt=1 and it stays 1. A following store of 0x5555 to 0x0010 is blocked, so memory still holds 0xBEEF after reset; wb_reg_wrt_ctrl=0 for all later instructions until reset.
- Alignment with ALIGN_CHECK_EN:
  - Word store 0xAAAA at 0x0011 -> wb_misalign=1 and memory unchanged.
  - Without the macro: the same store writes 0xAA to 0x0011 and 0x0012.
  - Without the macro: a word store 0x1357 at 0x00FF (DEPTH=256) writes 0x13 to 0xFF and 0x57 to 0x00.
- ALU pass-through: muxc=0, alu_output=0x0042, r0_result=0x0007 -> wb_id_write_data=0x0042 and wb_alu_r0_result=0x0007 one cycle later. mem_ex_forwarded_alu_output=0x0042 in the same cycle.
